// File: rtl/spdif_sample_writer.sv
// spdif_sample_writer
//   Wishbone master that stores decoded S/PDIF stereo frames into a 16-bit
//   block RAM organised as a ring buffer of DEPTH = 1<<ADDR_WIDTH words.
//   Each accepted frame is written as consecutive words at the write pointer;
//   the decoder is back-pressured when the ring cannot hold another frame.
//
//   Build option: SPDIF_WRITER_FULL24_EN
//     undefined : 2 words per frame, sample[23:8] per channel (truncated)
//     defined   : 4 words per frame, per channel hi word sample[23:8] (sel 11)
//                 then lo word {8'h00,sample[7:0]} (sel 01)
//
// Ports
//   wb_clk_i, wb_rst_n_i   clock, synchronous active-low reset
//   s_valid_i/s_ready_o    decoder frame handshake
//   s_left_i, s_right_i    24-bit two's complement samples
//   rd_ptr_i               consumer read pointer (word index)
//   wr_ptr_o               next word index to be written
//   level_o                (wr_ptr - rd_ptr) mod DEPTH
//   full_o                 no room for one more frame
//   frame_cnt_o            completed frames (wraps)
//   wbm_*                  Wishbone master write port
module spdif_sample_writer #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [23:0]           s_left_i,
  input  logic [23:0]           s_right_i,
  input  logic [ADDR_WIDTH-1:0] rd_ptr_i,
  output logic [ADDR_WIDTH-1:0] wr_ptr_o,
  output logic [ADDR_WIDTH-1:0] level_o,
  output logic                  full_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [1:0]            wbm_sel_o,
  output logic [31:0]           wbm_adr_o,
  output logic [15:0]           wbm_dat_o,
  input  logic                  wbm_ack_i
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
`ifdef SPDIF_WRITER_FULL24_EN
  localparam int unsigned WPF = 4;
`else
  localparam int unsigned WPF = 2;
`endif
  localparam int unsigned FULL_LIM = DEPTH - 1 - WPF;

`ifdef SPDIF_WRITER_FULL24_EN
  typedef enum logic [2:0] {S_IDLE, S_WR_LH, S_WR_LL, S_WR_RH, S_WR_RL} state_t;
  localparam state_t S_FIRST = S_WR_LH;
`else
  typedef enum logic [2:0] {S_IDLE, S_WR_L, S_WR_R} state_t;
  localparam state_t S_FIRST = S_WR_L;
`endif

  state_t                  state_q, state_d;
  logic [23:0]             left_q, left_d, right_q, right_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic                    cyc_q, cyc_d, stb_q, stb_d;
  logic [1:0]              sel_q, sel_d;
  logic [31:0]             adr_q, adr_d;
  logic [15:0]             dat_q, dat_d;
  logic                    rst_done_q;
  logic [ADDR_WIDTH-1:0]   level;
  logic                    full;
  logic                    accept;
  logic [15:0]             word_dat;
  logic [1:0]              word_sel;

  // Fill level and back-pressure; ready is held low until the cycle after reset
  assign level     = wr_ptr_q - rd_ptr_i;
  assign full      = 32'(level) > FULL_LIM;
  assign s_ready_o = rst_done_q & (state_q == S_IDLE) & ~full;
  assign accept    = s_valid_i & s_ready_o;

  // Next state and frame bookkeeping
  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    right_d     = right_q;
    wr_ptr_d    = wr_ptr_q;
    frame_cnt_d = frame_cnt_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          left_d  = s_left_i;
          right_d = s_right_i;
          state_d = S_FIRST;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
        end
      end
      default: begin
        if (wbm_ack_i) begin
          wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
          case (state_q)
`ifdef SPDIF_WRITER_FULL24_EN
            S_WR_LH: state_d = S_WR_LL;
            S_WR_LL: state_d = S_WR_RH;
            S_WR_RH: state_d = S_WR_RL;
`else
            S_WR_L:  state_d = S_WR_R;
`endif
            default: state_d = S_IDLE;
          endcase
          if (state_d == S_IDLE) begin
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
      end
    endcase
  end

  // Data word and byte selects for the word about to be presented
  always_comb begin
    word_dat = 16'h0000;
    word_sel = 2'b00;
    case (state_d)
`ifdef SPDIF_WRITER_FULL24_EN
      S_WR_LH: begin word_dat = left_d[23:8];           word_sel = 2'b11; end
      S_WR_LL: begin word_dat = {8'h00, left_d[7:0]};   word_sel = 2'b01; end
      S_WR_RH: begin word_dat = right_d[23:8];          word_sel = 2'b11; end
      S_WR_RL: begin word_dat = {8'h00, right_d[7:0]};  word_sel = 2'b01; end
`else
      S_WR_L:  begin word_dat = left_d[23:8];           word_sel = 2'b11; end
      S_WR_R:  begin word_dat = right_d[23:8];          word_sel = 2'b11; end
`endif
      default: ;
    endcase
  end

`ifndef SPDIF_WRITER_FULL24_EN
  // Sample LSBs are truncated in the 16-bit build
  logic unused_lsbs;
  assign unused_lsbs = ^{left_d[7:0], right_d[7:0]};
`endif

  // Bus payload reloads only when entering a new write state, so it holds until ack
  always_comb begin
    adr_d = adr_q;
    dat_d = dat_q;
    sel_d = sel_q;
    if ((state_d != S_IDLE) && (state_d != state_q)) begin
      adr_d = BASE_ADDR + (32'(wr_ptr_d) << 1);
      dat_d = word_dat;
      sel_d = word_sel;
    end
  end

  // State and output registers
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= S_IDLE;
      left_q      <= 24'h0;
      right_q     <= 24'h0;
      wr_ptr_q    <= '0;
      frame_cnt_q <= 16'h0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      sel_q       <= 2'b00;
      adr_q       <= 32'h0;
      dat_q       <= 16'h0;
      rst_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      right_q     <= right_d;
      wr_ptr_q    <= wr_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rst_done_q  <= 1'b1;
    end
  end

  assign wr_ptr_o    = wr_ptr_q;
  assign level_o     = level;
  assign full_o      = full;
  assign frame_cnt_o = frame_cnt_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = stb_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_spdif_sample_writer.sv
// Self-checking bench for spdif_sample_writer (ADDR_WIDTH=4 ring of 16 words).
// Follows SPDIF_WRITER_FULL24_EN when defined.
module tb_spdif_sample_writer;

  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0;
`ifdef SPDIF_WRITER_FULL24_EN
  localparam int WPF = 4;
`else
  localparam int WPF = 2;
`endif
  localparam int LIM = DEPTH - 1 - WPF;

  logic          clk, rst_n;
  logic          s_valid, s_ready;
  logic [23:0]   s_left, s_right;
  logic [AW-1:0] rd_ptr, wr_ptr, level;
  logic          full;
  logic [15:0]   frame_cnt;
  logic          cyc, stb, we;
  logic [1:0]    sel;
  logic [31:0]   adr;
  logic [15:0]   dat;
  logic          ack;

  int  ack_wait;
  int  wait_cnt;
  logic spur_ack;

  spdif_sample_writer #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_left_i(s_left), .s_right_i(s_right),
    .rd_ptr_i(rd_ptr), .wr_ptr_o(wr_ptr), .level_o(level), .full_o(full),
    .frame_cnt_o(frame_cnt),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_ack_i(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: ack after ack_wait stalled cycles (0 = combinational from stb)
  assign ack = (stb && (wait_cnt == ack_wait)) || spur_ack;
  always @(posedge clk) begin
    if (!stb || ack) wait_cnt <= 0;
    else             wait_cnt <= wait_cnt + 1;
  end

  typedef struct {
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
  } wr_t;
  wr_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int m_wr = 0;
  int m_rd = 0;
  int m_frames = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a frame becomes WPF consecutive ring words starting at m_wr
  function automatic void model_frame(input logic [23:0] l, input logic [23:0] r);
    int samples[2];
    wr_t w;
    samples[0] = int'(l);
    samples[1] = int'(r);
    for (int c = 0; c < 2; c++) begin
      w.adr = BASE + 32'(m_wr * 2);
      w.dat = 16'((samples[c] / 256) % 65536);
      w.sel = 2'b11;
      exp_q.push_back(w);
      m_wr = (m_wr + 1) % DEPTH;
      if (WPF == 4) begin
        w.adr = BASE + 32'(m_wr * 2);
        w.dat = 16'(samples[c] % 256);
        w.sel = 2'b01;
        exp_q.push_back(w);
        m_wr = (m_wr + 1) % DEPTH;
      end
    end
    m_frames = (m_frames + 1) % 65536;
  endfunction

  // Bus monitor: protocol sanity, hold-until-ack, and write scoreboard
  logic        prev_stall = 1'b0;
  logic [31:0] prev_adr;
  logic [15:0] prev_dat;
  logic [1:0]  prev_sel;
  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_stb_we", {29'h0, cyc, stb, we}, stb ? 32'h7 : 32'h0);
      if (stb) check("adr_vs_ptr", adr, BASE + 32'(int'(wr_ptr) * 2));
      if (prev_stall && stb) begin
        check("hold_adr", adr, prev_adr);
        check("hold_dat", {16'h0, dat}, {16'h0, prev_dat});
        check("hold_sel", {30'h0, sel}, {30'h0, prev_sel});
      end
      if (stb && ack) begin
        check("write_expected", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_adr", adr, e.adr);
          check("wr_dat", {16'h0, dat}, {16'h0, e.dat});
          check("wr_sel", {30'h0, sel}, {30'h0, e.sel});
        end
      end
      prev_stall <= stb && !ack;
      prev_adr   <= adr;
      prev_dat   <= dat;
      prev_sel   <= sel;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic push(input logic [23:0] l, input logic [23:0] r, input bit wait_done,
                      output int lat, output bit ok);
    @(negedge clk);
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      model_frame(l, r);
      @(posedge clk);
      #1 s_valid = 1'b0;
      if (wait_done) begin
        do begin
          @(negedge clk);
          lat++;
        end while (cyc && lat < 100);
      end
    end else begin
      s_valid = 1'b0;
    end
  endtask

  task automatic check_status(input string tag);
    int lvl;
    lvl = (m_wr - m_rd + DEPTH) % DEPTH;
    check({tag, "_wr_ptr"}, 32'(wr_ptr), 32'(m_wr));
    check({tag, "_frames"}, 32'(frame_cnt), 32'(m_frames));
    check({tag, "_level"}, 32'(level), 32'(lvl));
    check({tag, "_full"}, 32'(full), 32'(lvl > LIM));
    check({tag, "_ready"}, 32'(s_ready), 32'(!(lvl > LIM)));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic set_rd(input int v);
    m_rd = (v + DEPTH) % DEPTH;
    rd_ptr = AW'(m_rd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_wr = 0;
    m_frames = 0;
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, start, n, guard;
    bit ok;
    rst_n = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
    rd_ptr = '0; ack_wait = 0; spur_ack = 1'b0;

    // Reset held 4 cycles: every output low
    repeat (4) @(negedge clk);
    check("rst_bus", {27'h0, cyc, stb, we, sel}, 32'h0);
    check("rst_adr", adr, 32'h0);
    check("rst_dat", {16'h0, dat}, 32'h0);
    check("rst_ptrs", {23'h0, wr_ptr, level, full}, 32'h0);
    check("rst_frames", {16'h0, frame_cnt}, 32'h0);
    check("rst_ready", {31'h0, s_ready}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'h0, s_ready}, 32'h1);

    // Directed frame, combinational ack
    push(24'h123456, 24'hABCDEF, 1'b1, lat, ok);
    check("t2_accept", 32'(ok), 32'h1);
    check("t2_latency", 32'(lat), 32'(WPF + 1));
    check_status("t2");

    // Slow slave: 3 wait cycles per word
    ack_wait = 3;
    push(24'($urandom), 24'($urandom), 1'b1, lat, ok);
    check("t3_accept", 32'(ok), 32'h1);
    check("t3_latency", 32'(lat), 32'(WPF * 4 + 1));
    check_status("t3");
    ack_wait = 0;

    // Ack with no strobe must be ignored
    spur_ack = 1'b1;
    repeat (3) @(negedge clk);
    spur_ack = 1'b0;
    @(negedge clk);
    check_status("spur");

    // Randomized frames, level kept at or below the full threshold
    for (int k = 0; k < 16; k++) begin
      ack_wait = int'($urandom_range(0, 2));
      set_rd(m_wr - int'($urandom_range(0, LIM)));
      push(24'($urandom), 24'($urandom), 1'b1, lat, ok);
      check("rnd_accept", 32'(ok), 32'h1);
      check("rnd_latency", 32'(lat), 32'(WPF * (ack_wait + 1) + 1));
      check_status("rnd");
    end
    ack_wait = 0;

    // Fill the ring until full, then free space
    do_reset();
    set_rd(0);
    n = LIM / WPF + 1;
    for (int k = 0; k < n; k++) begin
      push(24'($urandom), 24'($urandom), 1'b1, lat, ok);
      check("fill_accept", 32'(ok), 32'h1);
    end
    check_status("fill");
    check("fill_full", 32'(full), 32'h1);
    check("fill_level", 32'(level), 32'(n * WPF));
    push(24'($urandom), 24'($urandom), 1'b1, lat, ok);
    check("blocked_when_full", 32'(ok), 32'h0);
    set_rd(WPF);
    @(negedge clk);
    check("unfull", 32'(full), 32'h0);
    push(24'($urandom), 24'($urandom), 1'b1, lat, ok);
    check("unfull_accept", 32'(ok), 32'h1);
    check_status("unfull");

    // Pointer wrap, then reset in the last word of a frame
    do_reset();
    while (m_wr != DEPTH - WPF) begin
      set_rd(m_wr);
      push(24'($urandom), 24'($urandom), 1'b1, lat, ok);
      check("wrap_pre_accept", 32'(ok), 32'h1);
    end
    set_rd(m_wr - 4);
    push(24'($urandom), 24'($urandom), 1'b1, lat, ok);
    check("wrap_accept", 32'(ok), 32'h1);
    check_status("wrap");
    check("wrap_ptr_zero", 32'(wr_ptr), 32'h0);

    ack_wait = 3;
    start = m_wr;
    push(24'($urandom), 24'($urandom), 1'b0, lat, ok);
    check("abort_accept", 32'(ok), 32'h1);
    guard = 0;
    while ((int'(wr_ptr) != (start + WPF - 1) % DEPTH) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reach_last", 32'(guard < 100), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_bus", {30'h0, cyc, stb}, 32'h0);
    check("abort_frames", {16'h0, frame_cnt}, 32'h0);
    check("abort_wr_ptr", 32'(wr_ptr), 32'h0);
    check("abort_words_left", 32'(exp_q.size()), 32'h1);
    exp_q.delete();
    rst_n = 1'b1;
    ack_wait = 0;
    m_wr = 0;
    m_frames = 0;
    @(negedge clk);
    check_status("post_abort");
    push(24'($urandom), 24'($urandom), 1'b1, lat, ok);
    check("post_abort_accept", 32'(ok), 32'h1);
    check_status("post_abort_frame");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
